// File: rtl/univ_shift_reg.sv
// Universal shift register (shift/rotate/load/clear) gated by a clock-enable divider.
// Optional: define USR_SYNC_EN to pass mode, din_l and din_r through 2-flop synchronisers.
module univ_shift_reg #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DIV   = 25000000
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [2:0]                 mode,
   input  logic                       din_l,
   input  logic                       din_r,
   input  logic [WIDTH-1:0]           pdata,
   output logic [WIDTH-1:0]           q,
   output logic                       sout_l,
   output logic                       sout_r,
   output logic                       tick,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHL  = 3'b001,
      MODE_SHR  = 3'b010,
      MODE_ROL  = 3'b011,
      MODE_ROR  = 3'b100,
      MODE_LOAD = 3'b101,
      MODE_CLR  = 3'b110,
      MODE_RSVD = 3'b111
   } mode_e;

   mode_e            mode_s;
   logic             din_l_s;
   logic             din_r_s;
   logic             upd_c;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q;
   logic             inc_c;

`ifdef USR_SYNC_EN
   logic [4:0] sync1_q, sync2_q;

   // Two-stage synchroniser for the asynchronous control/serial inputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {mode, din_l, din_r};
         sync2_q <= sync1_q;
      end
   end

   assign mode_s  = mode_e'(sync2_q[4:2]);
   assign din_l_s = sync2_q[1];
   assign din_r_s = sync2_q[0];
`else
   assign mode_s  = mode_e'(mode);
   assign din_l_s = din_l;
   assign din_r_s = din_r;
`endif

   assign upd_c     = (div_cnt_q == DIV_LAST);
   assign div_cnt_d = upd_c ? '0 : div_cnt_q + DIV_W'(1);

   // Register update on tick edges; everything holds between ticks
   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      inc_c = 1'b0;
      if (upd_c) begin
         case (mode_s)
            MODE_SHL: begin
               q_d   = {q_q[WIDTH-2:0], din_r_s};
               inc_c = 1'b1;
            end
            MODE_SHR: begin
               q_d   = {din_l_s, q_q[WIDTH-1:1]};
               inc_c = 1'b1;
            end
            MODE_ROL: begin
               q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               inc_c = 1'b1;
            end
            MODE_ROR: begin
               q_d   = {q_q[0], q_q[WIDTH-1:1]};
               inc_c = 1'b1;
            end
            MODE_LOAD: begin
               q_d   = pdata;
               cnt_d = '0;
            end
            MODE_CLR: begin
               q_d   = '0;
               cnt_d = '0;
            end
            default: begin
               q_d   = q_q;
               cnt_d = cnt_q;
            end
         endcase
      end
      if (inc_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div_cnt_q <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         tick_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         tick_q    <= upd_c;
      end
   end

   assign q      = q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];
   assign tick   = tick_q;
   assign cnt    = cnt_q;
   assign done   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: three instances (W4/D1, W4/D4, W8/D1).
module tb_univ_shift_reg;

`ifdef USR_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance a: WIDTH=4 DIV=1
   logic       clr_a = 1'b1, dl_a = 1'b0, dr_a = 1'b0;
   logic [2:0] mode_a = 3'b000;
   logic [3:0] pd_a = '0, q_a;
   logic [2:0] cnt_a;
   logic       sl_a, sr_a, tick_a, done_a;
   // instance b: WIDTH=4 DIV=4
   logic       clr_b = 1'b1, dl_b = 1'b0, dr_b = 1'b0;
   logic [2:0] mode_b = 3'b000;
   logic [3:0] pd_b = '0, q_b;
   logic [2:0] cnt_b;
   logic       sl_b, sr_b, tick_b, done_b;
   // instance c: WIDTH=8 DIV=1
   logic       clr_c = 1'b1, dl_c = 1'b0, dr_c = 1'b0;
   logic [2:0] mode_c = 3'b000;
   logic [7:0] pd_c = '0, q_c;
   logic [3:0] cnt_c;
   logic       sl_c, sr_c, tick_c, done_c;

   univ_shift_reg #(.WIDTH(4), .DIV(1)) u_a (
      .clk(clk), .clr(clr_a), .mode(mode_a), .din_l(dl_a), .din_r(dr_a), .pdata(pd_a),
      .q(q_a), .sout_l(sl_a), .sout_r(sr_a), .tick(tick_a), .cnt(cnt_a), .done(done_a));
   univ_shift_reg #(.WIDTH(4), .DIV(4)) u_b (
      .clk(clk), .clr(clr_b), .mode(mode_b), .din_l(dl_b), .din_r(dr_b), .pdata(pd_b),
      .q(q_b), .sout_l(sl_b), .sout_r(sr_b), .tick(tick_b), .cnt(cnt_b), .done(done_b));
   univ_shift_reg #(.WIDTH(8), .DIV(1)) u_c (
      .clk(clk), .clr(clr_c), .mode(mode_c), .din_l(dl_c), .din_r(dr_c), .pdata(pd_c),
      .q(q_c), .sout_l(sl_c), .sout_r(sr_c), .tick(tick_c), .cnt(cnt_c), .done(done_c));

   typedef struct {
      int         inst;
      logic [7:0] q;
      logic [3:0] cnt;
      logic       done;
      logic       tick;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] last_q[3];
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] obs_q(input int inst);
      case (inst)
         0:       return {4'b0, q_a};
         1:       return {4'b0, q_b};
         default: return q_c;
      endcase
   endfunction

   function automatic logic [3:0] obs_cnt(input int inst);
      case (inst)
         0:       return {1'b0, cnt_a};
         1:       return {1'b0, cnt_b};
         default: return cnt_c;
      endcase
   endfunction

   function automatic logic [3:0] obs_flags(input int inst);
      // {done, tick, sout_l, sout_r}
      case (inst)
         0:       return {done_a, tick_a, sl_a, sr_a};
         1:       return {done_b, tick_b, sl_b, sr_b};
         default: return {done_c, tick_c, sl_c, sr_c};
      endcase
   endfunction

   task automatic drive(input int inst, input logic [2:0] m, input logic dl, input logic dr,
                        input logic [7:0] pd);
      case (inst)
         0:       begin mode_a = m; dl_a = dl; dr_a = dr; pd_a = pd[3:0]; end
         1:       begin mode_b = m; dl_b = dl; dr_b = dr; pd_b = pd[3:0]; end
         default: begin mode_c = m; dl_c = dl; dr_c = dr; pd_c = pd; end
      endcase
   endtask

   task automatic pop_check(input string tag);
      exp_t       e;
      logic [3:0] f;
      logic       e_sl;
      if (sb_q.size() == 0) begin
         chk({tag, "/sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e    = sb_q.pop_front();
      f    = obs_flags(e.inst);
      e_sl = (e.inst == 2) ? e.q[7] : e.q[3];
      chk({tag, "/q"},      32'(obs_q(e.inst)), 32'(e.q));
      chk({tag, "/cnt"},    32'(obs_cnt(e.inst)), 32'(e.cnt));
      chk({tag, "/done"},   32'(f[3]), 32'(e.done));
      chk({tag, "/tick"},   32'(f[2]), 32'(e.tick));
      chk({tag, "/sout_l"}, 32'(f[1]), 32'(e_sl));
      chk({tag, "/sout_r"}, 32'(f[0]), 32'(e.q[0]));
      last_q[e.inst] = e.q;
   endtask

   // One update on a DIV=1 instance; with synchronisers the effect lands LAT edges later
   task automatic step(input int inst, input logic [2:0] m, input logic dl, input logic dr,
                       input logic [7:0] pd, input logic [7:0] eq, input logic [3:0] ec,
                       input string tag);
      int w;
      w = (inst == 2) ? 8 : 4;
      drive(inst, m, dl, dr, pd);
      sb_q.push_back('{inst: inst, q: eq, cnt: ec, done: (32'(ec) == w), tick: 1'b1});
      @(posedge clk); #1;
      for (int i = 0; i < LAT; i++) begin
         drive(inst, 3'b000, dl, dr, pd);
         chk({tag, "/lat_hold"}, 32'(obs_q(inst)), 32'(last_q[inst]));
         @(posedge clk); #1;
      end
      pop_check(tag);
   endtask

   initial begin
      logic [7:0] rol_seq[8];
      logic [7:0] bq;
      rol_seq = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
      last_q  = '{8'h00, 8'h00, 8'h00};

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back('{inst: i, q: 8'h00, cnt: 4'd0, done: 1'b0, tick: 1'b0});
         pop_check($sformatf("reset%0d", i));
      end

      // DIV=4: shift right with din_l=1, glitch din_l low only mid-period
      mode_b = 3'b010;
      dl_b   = 1'b1;
      clr_b  = 1'b0;
      for (int e = 1; e <= 13; e++) begin
         bq = (e < 4) ? 8'h00 : (e < 8) ? 8'h08 : (e < 12) ? 8'h0C : 8'h0E;
         sb_q.push_back('{inst: 1, q: bq, cnt: 4'((e / 4 > 4) ? 4 : e / 4),
                          done: 1'b0, tick: (e % 4 == 0)});
         @(posedge clk); #1;
         pop_check($sformatf("div4_e%0d", e));
         if (e % 4 == 0) dl_b = 1'b0;
         else            dl_b = 1'b1;
      end
      clr_b = 1'b1;

      // WIDTH=4 DIV=1: shift left, saturation, load, rotate right
      clr_a = 1'b0;
      step(0, 3'b001, 1'b0, 1'b1, 8'h0, 8'h01, 4'd1, "shl1");
      step(0, 3'b001, 1'b0, 1'b0, 8'h0, 8'h02, 4'd2, "shl2");
      step(0, 3'b001, 1'b0, 1'b1, 8'h0, 8'h05, 4'd3, "shl3");
      step(0, 3'b001, 1'b0, 1'b1, 8'h0, 8'h0B, 4'd4, "shl4");
      step(0, 3'b001, 1'b0, 1'b0, 8'h0, 8'h06, 4'd4, "shl5_sat");
      step(0, 3'b101, 1'b0, 1'b0, 8'h9, 8'h09, 4'd0, "load9");
      step(0, 3'b100, 1'b0, 1'b0, 8'h9, 8'h0C, 4'd1, "ror1");
      step(0, 3'b100, 1'b0, 1'b0, 8'h9, 8'h06, 4'd2, "ror2");
      step(0, 3'b010, 1'b1, 1'b0, 8'h9, 8'h0B, 4'd3, "shr1");

      // Asynchronous clear between clock edges
      #2 clr_a = 1'b1;
      #1;
      sb_q.push_back('{inst: 0, q: 8'h00, cnt: 4'd0, done: 1'b0, tick: 1'b0});
      pop_check("async_clr");
      #1 clr_a = 1'b0;
      drive(0, 3'b000, 1'b0, 1'b0, 8'h0);

      // WIDTH=8 DIV=1: load, eight rotate-lefts, reserved hold, sync clear
      clr_c = 1'b0;
      step(2, 3'b101, 1'b0, 1'b0, 8'hA5, 8'hA5, 4'd0, "c_load");
      for (int i = 0; i < 8; i++)
         step(2, 3'b011, 1'b0, 1'b0, 8'hA5, rol_seq[i], 4'(i + 1), $sformatf("c_rol%0d", i + 1));
      step(2, 3'b111, 1'b1, 1'b1, 8'h3C, 8'hA5, 4'd8, "c_rsvd");
      step(2, 3'b000, 1'b1, 1'b1, 8'h3C, 8'hA5, 4'd8, "c_hold");
      step(2, 3'b110, 1'b1, 1'b1, 8'h3C, 8'h00, 4'd0, "c_sclr");
      step(2, 3'b001, 1'b0, 1'b1, 8'h3C, 8'h01, 4'd1, "c_shl");
      step(2, 3'b111, 1'b0, 1'b0, 8'h3C, 8'h01, 4'd1, "c_rsvd2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
